// File: rtl/load_store_unit_if.sv
// Data-bus bundle between the load/store unit (master) and the memory system (slave).
interface load_store_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [31:0]           bus_wdata;
  logic [3:0]            bus_wstrb;
  logic                  bus_ready;
  logic [31:0]           bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: one word-bus transaction per request, byte/half lane
// steering for stores, sign/zero extension for loads, fault reporting without bus access.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            mem_op_length,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           store_data,
  output logic [31:0]           load_data,
  output logic                  done,
  output logic                  busy,
  output logic                  access_fault,
  load_store_unit_if.master     bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-3:0] word_q;
  logic [1:0]            off_q;
  logic [2:0]            len_q;
  logic                  we_q;
  logic [31:0]           sd_q;
  logic                  fault_q;
  logic [31:0]           load_data_q;

  logic                  req_any, illegal, misaligned, req_fault, go_bus;
  logic [31:0]           shifted, extracted, lane_wdata;
  logic [3:0]            lane_wstrb;

  assign req_any = mem_read | mem_write;

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (mem_op_length)
      3'b000:          illegal = 1'b0;
      3'b001:          misaligned = address[0];
      3'b010:          misaligned = |address[1:0];
      3'b100:          illegal = mem_write;
      3'b101: begin
        illegal    = mem_write;
        misaligned = address[0];
      end
      default:         illegal = 1'b1;
    endcase
  end

  // A no-op request (neither read nor write) completes cleanly whatever funct3 holds.
  assign req_fault = req_any & (illegal | misaligned);
  assign go_bus    = req_any & ~req_fault;

  assign shifted = bus.bus_rdata >> {off_q, 3'b000};

  always_comb begin
    case (len_q[1:0])
      2'b00: begin
        extracted  = {{24{~len_q[2] & shifted[7]}}, shifted[7:0]};
        lane_wstrb = 4'b0001 << off_q;
        lane_wdata = {4{sd_q[7:0]}};
      end
      2'b01: begin
        extracted  = {{16{~len_q[2] & shifted[15]}}, shifted[15:0]};
        lane_wstrb = 4'b0011 << off_q;
        lane_wdata = {2{sd_q[15:0]}};
      end
      default: begin
        extracted  = shifted;
        lane_wstrb = 4'b1111;
        lane_wdata = sd_q;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    busy             = (state_q != IDLE);
    done             = (state_q == DONE);
    access_fault     = (state_q == DONE) & fault_q;
    bus.bus_req      = 1'b0;
    bus.bus_we       = 1'b0;
    bus.bus_addr     = '0;
    bus.bus_wdata    = '0;
    bus.bus_wstrb    = '0;
    case (state_q)
      IDLE: begin
        if (start) state_d = go_bus ? ACCESS : DONE;
      end
      ACCESS: begin
        bus.bus_req  = 1'b1;
        bus.bus_we   = we_q;
        bus.bus_addr = {word_q, 2'b00};
        if (we_q) begin
          bus.bus_wdata = lane_wdata;
          bus.bus_wstrb = lane_wstrb;
        end
        if (bus.bus_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_q      <= '0;
      off_q       <= '0;
      len_q       <= '0;
      we_q        <= 1'b0;
      sd_q        <= '0;
      fault_q     <= 1'b0;
      load_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            word_q  <= address[ADDR_WIDTH-1:2];
            off_q   <= address[1:0];
            len_q   <= mem_op_length;
            we_q    <= mem_write;
            sd_q    <= store_data;
            fault_q <= req_fault;
            if (!go_bus) load_data_q <= '0;
          end
        end
        ACCESS: begin
          if (bus.bus_ready) load_data_q <= we_q ? '0 : extracted;
        end
        default: ;
      endcase
    end
  end

  assign load_data = load_data_q;

endmodule
